// File: rtl/stepdown_edgequal.sv
// Synchronized, filtered and blanked edge qualifier for a fixed-delay cell output.
// Optional glitch counter is built when STEPDOWN_EDGEQUAL_GLITCHCNT_EN is defined.
module stepdown_edgequal #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int BLANK_W     = 6
) (
  input  logic               CELCLK,
  input  logic               CELRSTN,
  input  logic               CELV,
  input  logic               CELG,
  input  logic               CELSUB,
  input  logic               i,
  input  logic [FILT_W-1:0]  filt_cnt,
  input  logic [BLANK_W-1:0] blank_cnt,
  input  logic               glitch_clr,
  output logic               o,
  output logic               rise,
  output logic               fall,
  output logic               blank,
  output logic [7:0]         glitch_cnt
);

  // Bit 1 of the encoding is the output level, so o comes straight off a flop.
  typedef enum logic [1:0] {
    LOW    = 2'b00,
    QUAL_H = 2'b01,
    HIGH   = 2'b11,
    QUAL_L = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_smp;
  state_t                 r_state;
  logic [FILT_W-1:0]      r_cnt;
  logic [BLANK_W-1:0]     r_blank_cnt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_is;
  logic                   w_blank;
  logic                   w_unused;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i};
  end

  assign w_is    = r_sync[SYNC_STAGES-1];
  assign w_blank = |r_blank_cnt;

  // The FSM evaluates a registered copy of is so that o, rise/fall and the
  // blanking load all take effect on the same qualifying edge.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) r_smp <= 1'b0;
    else          r_smp <= w_is;
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      r_state     <= LOW;
      r_cnt       <= '0;
      r_blank_cnt <= '0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_blank) r_blank_cnt <= r_blank_cnt - 1'b1;
      case (r_state)
        LOW: begin
          if (!w_blank && r_smp) begin
            if (filt_cnt == '0) begin
              r_state     <= HIGH;
              r_rise      <= 1'b1;
              r_blank_cnt <= blank_cnt;
            end else begin
              r_state <= QUAL_H;
              r_cnt   <= FILT_W'(1);
            end
          end
        end
        QUAL_H: begin
          if (!r_smp) begin
            r_state <= LOW;
          end else if (r_cnt >= filt_cnt) begin
            r_state     <= HIGH;
            r_rise      <= 1'b1;
            r_blank_cnt <= blank_cnt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!w_blank && !r_smp) begin
            if (filt_cnt == '0) begin
              r_state     <= LOW;
              r_fall      <= 1'b1;
              r_blank_cnt <= blank_cnt;
            end else begin
              r_state <= QUAL_L;
              r_cnt   <= FILT_W'(1);
            end
          end
        end
        QUAL_L: begin
          if (r_smp) begin
            r_state <= HIGH;
          end else if (r_cnt >= filt_cnt) begin
            r_state     <= LOW;
            r_fall      <= 1'b1;
            r_blank_cnt <= blank_cnt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= LOW;
      endcase
    end
  end

  assign o     = r_state[1];
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign blank = w_blank;

`ifdef STEPDOWN_EDGEQUAL_GLITCHCNT_EN
  logic       w_abort;
  logic [7:0] r_glitch;

  assign w_abort = ((r_state == QUAL_H) && !r_smp) || ((r_state == QUAL_L) && r_smp);

  // Clear has priority so a glitch on the clearing edge is not counted.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN)                         r_glitch <= 8'h00;
    else if (glitch_clr)                  r_glitch <= 8'h00;
    else if (w_abort && r_glitch != 8'hFF) r_glitch <= r_glitch + 8'h01;
  end

  assign glitch_cnt = r_glitch;
  assign w_unused   = ^{CELV, CELG, CELSUB};
`else
  assign glitch_cnt = 8'h00;
  assign w_unused   = ^{CELV, CELG, CELSUB, glitch_clr};
`endif

endmodule
